// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU-side SRAM-like port.
// Owner tags, access sizes and arbiter state encodings.
package cpu_bus_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner tags for accepted requests.
// Push while full and pop while empty are ignored.
module owner_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] buf_q, buf_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = buf_q[rptr_q];
  assign count = count_q;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    buf_d   = buf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      buf_d[wptr_q] = din;
      wptr_d = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like port between fetch and data masters.
// Data wins arbitration; a grant is held until mem_addr_ok.
module cpu_sram_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  outstanding
);

  localparam int CW = ((MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1) + 1;

  arb_state_e    state_q, state_d;
  logic          sel_data;
  logic          req_raw;
  logic          hs;
  logic          pop;
  logic          fifo_full, fifo_empty, head;
  logic [CW-1:0] fifo_cnt;

  always_comb begin
    sel_data = 1'b0;
    req_raw  = 1'b0;
    unique case (state_q)
      ARB_HOLD_I: begin
        sel_data = 1'b0;
        req_raw  = 1'b1;
      end
      ARB_HOLD_D: begin
        sel_data = 1'b1;
        req_raw  = 1'b1;
      end
      default: begin
        sel_data = data_req;
        req_raw  = (data_req | inst_req) & ~fifo_full;
      end
    endcase
  end

  assign mem_req   = req_raw & ~reset;
  assign mem_wr    = sel_data ? data_wr    : 1'b0;
  assign mem_size  = sel_data ? data_size  : SIZE_W;
  assign mem_wstrb = sel_data ? data_wstrb : 4'b0000;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wdata = sel_data ? data_wdata : 32'h0;

  assign hs           = mem_req & mem_addr_ok;
  assign inst_addr_ok = hs & ~sel_data;
  assign data_addr_ok = hs & sel_data;

  // Stray responses with nothing outstanding are dropped here.
  assign pop          = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & (head == OWNER_INST);
  assign data_data_ok = pop & (head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = 5'(fifo_cnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (mem_addr_ok) state_d = ARB_IDLE;
      end
      default: begin
        if (mem_req && !mem_addr_ok)
          state_d = sel_data ? ARB_HOLD_D : ARB_HOLD_I;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .pop   (pop),
    .din   (sel_data ? OWNER_DATA : OWNER_INST),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed self-checking bench for cpu_sram_arbiter.
// Inputs change after negedge; outputs checked 1 ns later.
module tb_cpu_sram_arbiter;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [4:0]  outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    inst_req = 0; data_req = 0; data_wr = 0;
    data_size = SIZE_W; data_wstrb = 4'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  initial begin
    reset = 1;
    inst_addr = 32'hBFC0_0000;
    data_addr = 32'h8000_0010;
    data_wdata = 32'h0;
    quiet();
    inst_req = 1;
    mem_addr_ok = 1;
    mem_data_ok = 1;
    cyc(); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_ok", inst_data_ok | data_data_ok, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_state", dut.state_q, ARB_IDLE);

    // single fetch
    cyc(); reset = 0; quiet();
    inst_req = 1; mem_addr_ok = 1; #1;
    chk("f_mem_req", mem_req, 1);
    chk("f_addr_ok", inst_addr_ok, 1);
    chk("f_daddr_ok", data_addr_ok, 0);
    chk("f_addr", mem_addr, 32'hBFC0_0000);
    chk("f_fields", {mem_wr, mem_size, mem_wstrb}, {1'b0, 2'd2, 4'h0});
    cyc(); quiet(); #1;
    chk("f_out1", outstanding, 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h3C1D_0000; #1;
    chk("f_iok", inst_data_ok, 1);
    chk("f_rdata", inst_rdata, 32'h3C1D_0000);
    chk("f_dok", data_data_ok, 0);
    cyc(); quiet(); #1;
    chk("f_out0", outstanding, 0);

    // simultaneous requests: data first
    cyc(); inst_req = 1; data_req = 1; mem_addr_ok = 1; #1;
    chk("p_addr_d", mem_addr, 32'h8000_0010);
    chk("p_dok", data_addr_ok, 1);
    chk("p_iok0", inst_addr_ok, 0);
    cyc(); data_req = 0; #1;
    chk("p_addr_i", mem_addr, 32'hBFC0_0000);
    chk("p_iok", inst_addr_ok, 1);
    cyc(); quiet(); mem_data_ok = 1; mem_rdata = 32'h1111_1111; #1;
    chk("p_r1_d", data_data_ok, 1);
    chk("p_r1_i", inst_data_ok, 0);
    chk("p_r1_data", data_rdata, 32'h1111_1111);
    cyc(); mem_rdata = 32'h2222_2222; #1;
    chk("p_r2_i", inst_data_ok, 1);
    chk("p_r2_d", data_data_ok, 0);
    cyc(); quiet(); #1;
    chk("p_out0", outstanding, 0);

    // hold on inst while data arrives
    cyc(); inst_req = 1; #1;
    chk("h_req", mem_req, 1);
    chk("h_addr0", mem_addr, 32'hBFC0_0000);
    cyc(); data_req = 1; data_addr = 32'h8000_0020; #1;
    chk("h_state1", dut.state_q, ARB_HOLD_I);
    chk("h_addr1", mem_addr, 32'hBFC0_0000);
    chk("h_dok1", data_addr_ok, 0);
    cyc(); #1;
    chk("h_addr2", mem_addr, 32'hBFC0_0000);
    chk("h_req2", mem_req, 1);
    cyc(); mem_addr_ok = 1; #1;
    chk("h_addr3", mem_addr, 32'hBFC0_0000);
    chk("h_iok3", inst_addr_ok, 1);
    chk("h_dok3", data_addr_ok, 0);
    cyc(); inst_req = 0; #1;
    chk("h_state4", dut.state_q, ARB_IDLE);
    chk("h_addr4", mem_addr, 32'h8000_0020);
    chk("h_dok4", data_addr_ok, 1);

    // push and pop together at outstanding 2
    cyc(); data_req = 0; inst_req = 1; mem_addr_ok = 1;
    mem_data_ok = 1; mem_rdata = 32'hAAAA_0001; #1;
    chk("pp_out2", outstanding, 2);
    chk("pp_iok", inst_data_ok, 1);
    chk("pp_dok", data_data_ok, 0);
    chk("pp_aok", inst_addr_ok, 1);
    cyc(); quiet(); #1;
    chk("pp_out", outstanding, 2);
    cyc(); mem_data_ok = 1; #1;
    chk("pp_d1", data_data_ok, 1);
    cyc(); #1;
    chk("pp_i2", inst_data_ok, 1);
    cyc(); #1;
    chk("e_out", outstanding, 0);
    chk("e_iok", inst_data_ok, 0);
    chk("e_dok", data_data_ok, 0);
    cyc(); quiet(); #1;
    chk("e_out2", outstanding, 0);

    // fill to MAX_OUTSTANDING
    for (int i = 0; i < 4; i++) begin
      cyc(); inst_req = 1; mem_addr_ok = 1; #1;
      chk("fill_aok", inst_addr_ok, 1);
    end
    cyc(); #1;
    chk("full_req", mem_req, 0);
    chk("full_out", outstanding, 4);
    chk("full_aok", inst_addr_ok, 0);
    cyc(); mem_data_ok = 1; #1;
    chk("full_pop_req", mem_req, 0);
    chk("full_pop_iok", inst_data_ok, 1);
    cyc(); mem_data_ok = 0; #1;
    chk("unblk_req", mem_req, 1);
    chk("unblk_aok", inst_addr_ok, 1);
    cyc(); quiet(); #1;
    chk("unblk_out", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_data_ok = 1; #1;
      chk("drain_iok", inst_data_ok, 1);
    end
    cyc(); quiet(); #1;
    chk("drain_out", outstanding, 0);

    // async reset mid-operation
    for (int i = 0; i < 3; i++) begin
      cyc(); inst_req = 1; mem_addr_ok = 1;
    end
    cyc(); quiet(); data_req = 1; #1;
    chk("r_req", mem_req, 1);
    cyc(); #1;
    chk("r_hold", dut.state_q, ARB_HOLD_D);
    chk("r_out3", outstanding, 3);
    #1 reset = 1; mem_data_ok = 1;
    #1;
    chk("r_out0", outstanding, 0);
    chk("r_idle", dut.state_q, ARB_IDLE);
    chk("r_mreq", mem_req, 0);
    chk("r_dok", data_data_ok | inst_data_ok, 0);
    cyc(); reset = 0; quiet();
    inst_req = 1; mem_addr_ok = 1; #1;
    chk("ra_aok", inst_addr_ok, 1);
    cyc(); quiet(); mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D; #1;
    chk("ra_iok", inst_data_ok, 1);
    chk("ra_rdata", inst_rdata, 32'h0BAD_F00D);
    cyc(); quiet(); #1;
    chk("ra_out", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Two-master arbiter that shares a single SRAM-like memory port between instruction fetch (IF stage) and data access (EXE/MEM stages). It sits between the pipeline and the SRAM-like-to-AXI bridge. It grants requests with data-side priority and holds a grant until the address handshake completes. It keeps an in-order FIFO of owners for accepted requests, so each `mem_data_ok`/`mem_rdata` goes back to the master that issued it.

## Interface
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unanswered requests; power of two, 2..16
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `inst_req` in 1: fetch request; held until `inst_addr_ok`
- `inst_addr` in 32: fetch address; always a word read
- `inst_addr_ok` out 1: fetch request accepted this cycle
- `inst_data_ok` out 1: fetch data valid this cycle
- `inst_rdata` out 32: fetch data; equals `mem_rdata`
- `data_req` in 1: load/store request; held until `data_addr_ok`
- `data_wr` in 1: 1 = store
- `data_size` in 2: 0 = byte, 1 = half, 2 = word
- `data_wstrb` in 4: store byte enables
- `data_addr` in 32: data address
- `data_wdata` in 32: store data
- `data_addr_ok` out 1: data request accepted
- `data_data_ok` out 1: load data returned or store completed
- `data_rdata` out 32: load data; equals `mem_rdata`
- `mem_req` out 1: request to the bridge
- `mem_wr` out 1, `mem_size` out 2, `mem_wstrb` out 4, `mem_addr` out 32, `mem_wdata` out 32: fields of the granted master. For a fetch: `mem_wr` = 0, `mem_size` = 2, `mem_wstrb` = 0.
- `mem_addr_ok` in 1: bridge accepted the request
- `mem_data_ok` in 1: bridge response; always returned in request order
- `mem_rdata` in 32: response data
- `outstanding` out 5: current FIFO occupancy

## Operation
- Grant FSM states:
  - IDLE: no grant held.
  - HOLD_I: fetch request presented, not yet accepted.
  - HOLD_D: data request presented, not yet accepted.
- In IDLE:
  - Grant goes to data if `data_req`, else to inst if `inst_req`.
  - `mem_req` = granted req & ~full.
  - If `mem_req` & ~`mem_addr_ok`: enter HOLD_D or HOLD_I for the granted owner.
- In HOLD_x:
  - The grant stays fixed on x and `mem_req` = 1, whatever the other master does.
  - On `mem_addr_ok`: return to IDLE.
  - The next grant is re-arbitrated in the following cycle, never in the same cycle.
- Handshake: `mem_req` & `mem_addr_ok` pushes the owner bit (0 = inst, 1 = data) into the owner FIFO. The same cycle, `addr_ok` pulses to the granted master only.
- Response: on `mem_data_ok` with FIFO not empty, pop the head and pulse `inst_data_ok` or `data_data_ok` per the head bit. The other `data_ok` stays 0.
- `mem_data_ok` with FIFO empty is a protocol error: dropped, no `data_ok` pulse, count unchanged.
- Full: count == `MAX_OUTSTANDING` forces `mem_req` = 0 in IDLE.
  - A pop in the same cycle does not unblock the push; the request issues the next cycle.
  - HOLD_x can only be entered when not full, so `mem_req` never drops mid-request.
- Simultaneous push and pop: both pointers advance and the count is unchanged.
- Count and pointer arithmetic: pointers are log2(MAX_OUTSTANDING) bits and wrap modulo depth. `outstanding` is 0..MAX_OUTSTANDING and never wraps.
- Stores occupy a FIFO entry like loads. Their `data_data_ok` feeds the MEM stage's unfinished-store counter.

## Timing
- Reset values: FSM = IDLE, FIFO empty, `outstanding` = 0.
  - While `reset` is high, `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok` and `data_data_ok` are forced to 0.
- `addr_ok` and `data_ok` outputs are combinational from bridge inputs and registered state: zero added latency.
- `mem_*` request fields are combinational from the granted master. No `mem_*` output path is combinational from `mem_addr_ok`, so there is no loop through the bridge.
- Reset mid-operation clears all state immediately. The bridge is reset alongside, so no pre-reset response reaches a master.

## Structure
- Shared package `cpu_bus_pkg`:
  - owner constants `OWNER_INST` = 0, `OWNER_DATA` = 1
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`
  - FSM state encodings `ARB_IDLE`, `ARB_HOLD_I`, `ARB_HOLD_D`
- Sub-module `owner_fifo`:
  - parameterised depth, 1-bit wide
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`
  - asynchronous reset
- Top level holds the FSM and the muxing.

## Test plan
- Fetch from `inst_addr` 0xBFC00000 with `mem_addr_ok` = 1 in cycle 0 -> `inst_addr_ok` = 1 in cycle 0. Response `mem_data_ok` with 0x3C1D0000 in cycle 2 -> `inst_data_ok` = 1 and `inst_rdata` = 0x3C1D0000 in cycle 2, `data_data_ok` = 0.
- `inst_req` and `data_req` (load 0x80000010) both rise with `mem_addr_ok` = 1 -> `mem_addr` = 0x80000010 first, then `inst_addr` in the next cycle. Two responses -> `data_data_ok` first, then `inst_data_ok`.
- `inst_req` with `mem_addr_ok` held low for 3 cycles, `data_req` rising in cycle 1 -> FSM in HOLD_I and `mem_addr` = `inst_addr` throughout. The data request is granted the cycle after the inst acceptance.
- `MAX_OUTSTANDING` = 4, four accepted requests with no response, `inst_req` still high -> `mem_req` = 0 and `outstanding` = 4. One `mem_data_ok` -> `mem_req` = 1 in the next cycle.
- `outstanding` = 2, push and pop in the same cycle -> `outstanding` stays 2 and the response routes to the older owner. Also: `mem_data_ok` with an empty FIFO -> no `data_ok` pulse.
- `reset` asserted mid-cycle with 3 outstanding requests and FSM in HOLD_D -> `outstanding` = 0, FSM = IDLE and `mem_req` = 0 without waiting for a clock edge. After release, a new fetch completes normally.
